// File: rtl/freq_div_prog.sv
// freq_div_prog: runtime-programmable square-wave divider with tick strobe.
// Half-period limit loads via a shadow register, applied at a toggle edge.
//
// Ports:
//   clk_i   system clock, all logic on its rising edge
//   rst_i   synchronous active-high reset
//   en_i    count enable; low freezes count, clk_div and act
//   lim_i   requested half-period minus 1
//   load_i  one-cycle strobe capturing lim_i
//   clk_div divided square wave (registered)
//   tick_o  one-cycle pulse on each clk_div toggle (registered)
//   pend_o  a captured limit is waiting to be applied
module freq_div_prog #(
  parameter int              WIDTH     = 26,
  parameter logic [WIDTH-1:0] DEF_LIM  = 26'd49_999_999,
  parameter bit              IMMEDIATE = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] lim_i,
  input  logic             load_i,
  output logic             clk_div,
  output logic             tick_o,
  output logic             pend_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] act;
  logic [WIDTH-1:0] pend;
  logic             pend_v;
  logic             div_q;
  logic             tick_q;
  logic             hit;
  logic             imm_ld;

  assign hit    = en_i && (cnt == act);
  assign imm_ld = IMMEDIATE && load_i;

  // Immediate loads restart the count and win over a coincident
  // boundary. Otherwise a new limit only takes effect at a toggle,
  // so the half-period in flight always finishes with the old one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt    <= '0;
      act    <= DEF_LIM;
      pend   <= '0;
      pend_v <= 1'b0;
      div_q  <= 1'b0;
      tick_q <= 1'b0;
    end else if (imm_ld) begin
      act    <= lim_i;
      cnt    <= '0;
      tick_q <= 1'b0;
    end else if (hit) begin
      cnt    <= '0;
      div_q  <= ~div_q;
      tick_q <= 1'b1;
      if (load_i) begin
        act    <= lim_i;
        pend_v <= 1'b0;
      end else if (pend_v) begin
        act    <= pend;
        pend_v <= 1'b0;
      end
    end else begin
      tick_q <= 1'b0;
      if (en_i) begin
        cnt <= cnt + ONE;
      end
      if (load_i) begin
        pend   <= lim_i;
        pend_v <= 1'b1;
      end
    end
  end

  assign clk_div = div_q;
  assign tick_o  = tick_q;
  assign pend_o  = pend_v;

endmodule

// File: tb/tb_freq_div_prog.sv
// tb_freq_div_prog: random plus directed check of freq_div_prog.
// Two instances: deferred (DEF_LIM=3) and immediate (DEF_LIM=7).
module tb_freq_div_prog;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       en_i = 1'b0;
  logic       load_i = 1'b0;
  logic [7:0] lim_i = 8'd0;
  logic       d0, t0, p0, d1, t1, p1;

  int nvec = 0;
  int nerr = 0;

  int half [2];
  int pos  [2];
  int lvl  [2];
  int tk   [2];
  int pv   [2];
  int pval [2];
  int dl   [2] = '{3, 7};
  int im   [2] = '{0, 1};

  always #5 clk_i = ~clk_i;

  freq_div_prog #(
    .WIDTH(8), .DEF_LIM(8'd3), .IMMEDIATE(1'b0)
  ) u0 (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
    .lim_i(lim_i), .load_i(load_i),
    .clk_div(d0), .tick_o(t0), .pend_o(p0)
  );

  freq_div_prog #(
    .WIDTH(8), .DEF_LIM(8'd7), .IMMEDIATE(1'b1)
  ) u1 (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
    .lim_i(lim_i), .load_i(load_i),
    .clk_div(d1), .tick_o(t1), .pend_o(p1)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input int a, input int e);
    nvec++;
    if (a != e) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d", nm, a, e);
    end
  endtask

  // Model: half-period length and position inside it.
  task automatic step(input int i, input logic r, input logic e,
                      input logic l, input int v);
    if (r) begin
      half[i] = dl[i] + 1;
      pos[i]  = 0;
      lvl[i]  = 0;
      tk[i]   = 0;
      pv[i]   = 0;
      pval[i] = 0;
    end else if (im[i] == 1 && l) begin
      half[i] = v + 1;
      pos[i]  = 0;
      tk[i]   = 0;
    end else if (e && pos[i] == half[i] - 1) begin
      lvl[i] = 1 - lvl[i];
      tk[i]  = 1;
      pos[i] = 0;
      if (l) begin
        half[i] = v + 1;
        pv[i]   = 0;
      end else if (pv[i] == 1) begin
        half[i] = pval[i] + 1;
        pv[i]   = 0;
      end
    end else begin
      tk[i] = 0;
      if (e) pos[i]++;
      if (l) begin
        pv[i]   = 1;
        pval[i] = v;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic e,
                     input logic l, input int v);
    rst_i  = r;
    en_i   = e;
    load_i = l;
    lim_i  = 8'(v);
    @(posedge clk_i);
    step(0, r, e, l, v);
    step(1, r, e, l, v);
    #1;
    chk("div0", d0, lvl[0]);
    chk("tick0", t0, tk[0]);
    chk("pend0", p0, pv[0]);
    chk("div1", d1, lvl[1]);
    chk("tick1", t1, tk[1]);
    chk("pend1", p1, 0);
  endtask

  initial begin
    int f0, l0, n0, b0, f1, n1, n;
    logic [15:0] m0, m1;
    logic r, e, l;
    int v;
    for (int i = 0; i < 2; i++) begin
      half[i] = dl[i] + 1;
      pos[i] = 0; lvl[i] = 0; tk[i] = 0;
      pv[i] = 0; pval[i] = 0;
    end

    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    chk("rst_div0", d0, 0);
    chk("rst_tick0", t0, 0);
    chk("rst_pend0", p0, 0);
    chk("rst_div1", d1, 0);

    f0 = 0; l0 = 0; n0 = 0; b0 = 0; f1 = 0; n1 = 0;
    for (int k = 1; k <= 40; k++) begin
      cyc(0, 1, 0, 0);
      if (t0) begin
        if (f0 == 0) f0 = k;
        else if (k - l0 != 4) b0++;
        l0 = k;
        n0++;
      end
      if (t1) begin
        if (f1 == 0) f1 = k;
        n1++;
      end
    end
    chk("first_tick0", f0, 4);
    chk("ticks0", n0, 10);
    chk("spacing0", b0, 0);
    chk("first_tick1", f1, 8);
    chk("ticks1", n1, 5);

    cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 1);
    chk("c_pend", p0, 1);
    m0 = '0;
    m1 = '0;
    for (int k = 3; k <= 10; k++) begin
      cyc(0, 1, 0, 0);
      m0[k] = t0;
      m1[k] = t1;
    end
    chk("c_mask0", m0, 16'h0550);
    chk("c_mask1", m1, 16'h0550);
    chk("c_pend_clr", p0, 0);

    cyc(0, 0, 1, 5);
    cyc(0, 0, 1, 0);
    chk("d_pend", p0, 1);
    n = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc(0, 1, 0, 0);
      if (k > 4) n += int'(t0);
    end
    chk("d_ticks_high", n, 6);

    cyc(0, 1, 1, 2);
    chk("e_tick", t0, 1);
    chk("e_pend", p0, 0);
    m0 = '0;
    for (int k = 1; k <= 3; k++) begin
      cyc(0, 1, 0, 0);
      m0[k] = t0;
    end
    chk("e_mask", m0, 16'h0008);

    n = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc(0, 0, k == 5, 4);
      n += int'(t0);
    end
    chk("f_ticks", n, 0);
    chk("f_pend", p0, 1);
    for (int k = 0; k < 20; k++) cyc(0, 1, 0, 0);

    rst_i = 1'b1;
    #2;
    rst_i = 1'b0;
    cyc(0, 1, 0, 0);
    for (int k = 0; k < 40; k++) begin
      if (lvl[0] == 1 && pos[0] != half[0] - 1) break;
      cyc(0, 1, 0, 0);
    end
    chk("g_reach", d0, 1);
    cyc(0, 1, 1, 6);
    chk("g_pend", p0, 1);
    cyc(1, 1, 0, 0);
    chk("g_div", d0, 0);
    chk("g_pend_clr", p0, 0);
    m0 = '0;
    for (int k = 1; k <= 4; k++) begin
      cyc(0, 1, 0, 0);
      m0[k] = t0;
    end
    chk("g_mask", m0, 16'h0010);

    for (int k = 0; k < 3000; k++) begin
      r = ($urandom_range(0, 299) == 0);
      e = ($urandom_range(0, 7) != 0);
      l = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) v = 255;
      else v = int'($urandom_range(0, 9));
      cyc(r, e, l, v);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/freq_div_prog.md
Name: freq_div_prog

Overview:
- Runtime-programmable clock divider. Successor to the fixed 4-entry divider.
- Produces a square-wave `clk_div` and a one-cycle `tick_o` strobe at each toggle.
- Half-period limit is loaded at run time through a shadow register and applied glitch-free at a half-period boundary, or immediately when `IMMEDIATE=1`.
- Sits between the system clock (50 MHz) and LED/display/UART pacing logic; pacing logic uses `tick_o` as a clock enable.

Parameters:
- `WIDTH`, 26: counter and limit width in bits.
- `DEF_LIM`, 26'd49_999_999: active limit after reset. Half-period is `DEF_LIM+1` cycles. Must fit in `WIDTH`.
- `IMMEDIATE`, 0: 0 = a loaded limit is applied at the next toggle boundary; 1 = a loaded limit is applied on the next edge and the count restarts.

Ports:
- `clk_i`  input  1  system clock; all logic is on its rising edge.
- `rst_i`  input  1  reset, synchronous, active-high.
- `en_i`  input  1  count enable; low freezes the counter and `clk_div`.
- `lim_i`  input  WIDTH  requested half-period minus 1.
- `load_i`  input  1  one-cycle strobe that captures `lim_i`.
- `clk_div`  output  1  divided square wave, registered.
- `tick_o`  output  1  one-cycle pulse on each cycle where `clk_div` toggles, registered.
- `pend_o`  output  1  a captured limit is waiting to be applied.

Behaviour:
- Reset (`rst_i=1` at an edge; overrides everything, including mid-period):
  - count=0, active limit (`act`)=`DEF_LIM`, pending register=0.
  - `clk_div`=0, `tick_o`=0, `pend_o`=0.
- Normal operation (`en_i=1`, `IMMEDIATE=0`), each edge:
  - If count==`act`: count<=0, `clk_div`<=~`clk_div`, `tick_o`<=1.
  - Otherwise: count<=count+1, `tick_o`<=0.
- Output period is 2*(`act`+1) clk cycles; duty cycle is exactly 50%.
- `act`=0 is legal: `clk_div` toggles every cycle (clk/2) and `tick_o` stays high continuously.
- Load (`IMMEDIATE=0`):
  - `load_i=1`: pending<=`lim_i`, `pend_o`<=1.
  - A later load before the boundary overwrites pending (last write wins).
  - At the boundary edge (count==`act`, `en_i=1`) with pending valid: `act`<=pending, `pend_o`<=0.
  - `load_i` on the boundary edge itself: `lim_i` is applied directly at that edge (bypasses pending) and `pend_o`<=0.
  - Current half-period always completes with the old limit; there are no runt or stretched pulses beyond the programmed values.
- Load (`IMMEDIATE=1`):
  - `load_i=1`: `act`<=`lim_i`, count<=0, `clk_div` unchanged, `tick_o`<=0, `pend_o` stays 0.
  - This takes priority over a coincident boundary, so no toggle occurs on that edge.
- Enable low (`en_i=0`):
  - count, `clk_div` and `act` hold; `tick_o`<=0.
  - `load_i` is still captured into pending (`IMMEDIATE=0`) or into `act` with count cleared (`IMMEDIATE=1`).
  - Pending is applied at the first boundary after `en_i` returns high.
- Width rules:
  - Count compares with equality only and never exceeds `act`, because any limit change resets or aligns the count to 0.
  - No wrap-around path exists; `lim_i`=all-ones gives a half-period of 2^WIDTH cycles.
- Latency:
  - `clk_div` and `tick_o` change on the same edge at which count==`act` is evaluated.
  - First toggle after reset release is on edge `DEF_LIM`+1, counting the first non-reset edge as edge 1.

Test Plan:
- `WIDTH=8`, `DEF_LIM=3`, reset then `en_i=1` for 40 cycles -> `clk_div` toggles every 4 cycles (period 8), `tick_o` 1-cycle pulses every 4 cycles, `pend_o`=0.
- `IMMEDIATE=0`, `DEF_LIM=3`; `load_i` with `lim_i=1` at count=1 -> `pend_o`=1; remaining half-period finishes at 4 cycles total; subsequent half-periods are 2 cycles; `pend_o`=0 after the boundary.
- `IMMEDIATE=0`: load 5 then load 0 before the boundary -> 0 applied (clk/2 output, `tick_o` held high); load with `lim_i=2` on the exact boundary edge -> next half-period is 3 cycles, `pend_o` never set.
- `IMMEDIATE=1`, `DEF_LIM=7`; `load_i` `lim_i=2` at count=5 -> no toggle on that edge, count restarts, next toggle 3 cycles later, `clk_div` level preserved.
- `en_i=0` for 10 cycles mid-period -> `clk_div`/count frozen, `tick_o`=0; a load during the freeze is applied at the first boundary after `en_i=1`.
- `rst_i` asserted mid-period with `clk_div`=1 and pending set -> next edge: `clk_div`=0, `pend_o`=0, `act`=`DEF_LIM`; asynchronous `rst_i` pulse between edges has no effect.
